// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared state type and default limits for the output scheduler
package sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam int DEF_MAXLEN = 1522;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first requesting port at or after ptr, with wrap
module rr_pick #(
    parameter int P_WIDTH = 3
) (
    input  logic [P_WIDTH-1:0]         req,
    input  logic [$clog2(P_WIDTH)-1:0] ptr,
    output logic [P_WIDTH-1:0]         onehot,
    output logic [$clog2(P_WIDTH)-1:0] idx
);

    localparam int SEL_W = $clog2(P_WIDTH);

    logic             found;
    logic [SEL_W-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 0; k < P_WIDTH; k++) begin
            pos = SEL_W'((int'(ptr) + k) % P_WIDTH);
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/output_scheduler.sv
// rtl/output_scheduler.sv - frame-level round-robin scheduler for one output port
module output_scheduler
    import sched_pkg::*;
#(
    parameter int P_WIDTH  = 3,
    parameter int P_MAXLEN = DEF_MAXLEN,
    parameter int P_CNT_W  = DEF_CNT_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [P_WIDTH-1:0]         req_i,
    input  logic [P_WIDTH-1:0]         valid_i,
    input  logic [P_WIDTH-1:0]         last_i,
    input  logic                       ready_i,
    output logic [P_WIDTH-1:0]         grant_o,
    output logic [$clog2(P_WIDTH)-1:0] sel_o,
    output logic                       xfer_o,
    output logic                       busy_o,
    output logic                       abort_o,
    output logic [P_CNT_W-1:0]         frames_o
);

    localparam int                SEL_W     = $clog2(P_WIDTH);
    localparam int                BEAT_W    = $clog2(P_MAXLEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(P_MAXLEN - 1);
    localparam logic [SEL_W-1:0]  TOP_PORT  = SEL_W'(P_WIDTH - 1);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   next_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic [P_WIDTH-1:0] pick_onehot;
    logic [BEAT_W-1:0]  beat_cnt;
    logic               sel_last;
    logic               sel_req;
    logic               watchdog;

    rr_pick #(
        .P_WIDTH (P_WIDTH)
    ) u_pick (
        .req    (req_i),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign xfer_o   = valid_i[sel_o] & ready_i & busy_o;
    assign sel_last = last_i[sel_o];
    assign sel_req  = req_i[sel_o];
    assign watchdog = xfer_o && (beat_cnt == LAST_BEAT);
    assign next_ptr = (sel_o == TOP_PORT) ? '0 : sel_o + SEL_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            grant_o  <= '0;
            sel_o    <= '0;
            busy_o   <= 1'b0;
            abort_o  <= 1'b0;
            frames_o <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else begin
            abort_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_i) begin
                        state    <= ST_GRANT;
                        grant_o  <= pick_onehot;
                        sel_o    <= pick_idx;
                        busy_o   <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // A last beat completes the frame even if the watchdog or a dropped request coincide
                    if (xfer_o && sel_last) begin
                        state    <= ST_IDLE;
                        grant_o  <= '0;
                        busy_o   <= 1'b0;
                        ptr      <= next_ptr;
                        frames_o <= frames_o + P_CNT_W'(1);
                    end else if (watchdog || !sel_req) begin
                        state   <= ST_ABORT;
                        grant_o <= '0;
                        busy_o  <= 1'b0;
                        abort_o <= 1'b1;
                        ptr     <= next_ptr;
                    end else if (xfer_o) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
                ST_ABORT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// tb/tb_output_scheduler.sv - self-checking bench for output_scheduler
module tb_output_scheduler;

    localparam int W      = 3;
    localparam int MAXLEN = 8;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [W-1:0]   req_i, valid_i, last_i, grant_o;
    logic           ready_i, xfer_o, busy_o, abort_o;
    logic [1:0]     sel_o;
    logic [15:0]    frames_o;

    int total = 0;
    int bad   = 0;

    output_scheduler #(
        .P_WIDTH  (W),
        .P_MAXLEN (MAXLEN),
        .P_CNT_W  (16)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .valid_i  (valid_i),
        .last_i   (last_i),
        .ready_i  (ready_i),
        .grant_o  (grant_o),
        .sel_o    (sel_o),
        .xfer_o   (xfer_o),
        .busy_o   (busy_o),
        .abort_o  (abort_o),
        .frames_o (frames_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0] req;
        logic [2:0] valid;
        logic [2:0] last;
        logic       ready;
        logic [2:0] grant;
        logic       busy;
        logic       abort;
        logic       xfer;
        int         sel;
        int         frames;
    } vec_t;

    vec_t tv[11];

    int   order[4];
    int   idle, pulses, n, xfers, sent, aborts;
    logic rd;

    logic [2:0] r_req, r_valid, r_last;
    logic       r_rdy;
    int m_owner, m_ptr, m_beats, m_sel, m_abort, m_frames, p;
    int e_grant, e_busy, e_abort, e_xfer;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] v, input logic [2:0] l, input logic rdy);
        req_i   = r;
        valid_i = v;
        last_i  = l;
        ready_i = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        req_i   = '0;
        valid_i = '0;
        last_i  = '0;
        ready_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic model_eval();
        e_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
        e_busy  = (m_owner >= 0) ? 1 : 0;
        e_abort = m_abort;
        e_xfer  = (m_owner >= 0 && ((int'(r_valid) >> m_owner) & 1) == 1 && r_rdy) ? 1 : 0;
    endtask

    task automatic model_next();
        if (m_abort == 1) begin
            m_abort = 0;
        end else if (m_owner < 0) begin
            if (r_req != 3'b000) begin
                for (int k = 0; k < W; k++) begin
                    p = (m_ptr + k) % W;
                    if (m_owner < 0 && ((int'(r_req) >> p) & 1) == 1) m_owner = p;
                end
                m_sel   = m_owner;
                m_beats = 0;
            end
        end else begin
            if (e_xfer == 1) m_beats++;
            if (e_xfer == 1 && ((int'(r_last) >> m_owner) & 1) == 1) begin
                m_frames = (m_frames + 1) % 65536;
                m_ptr    = (m_owner + 1) % W;
                m_owner  = -1;
            end else if ((e_xfer == 1 && m_beats == MAXLEN) || ((int'(r_req) >> m_owner) & 1) == 0) begin
                m_abort = 1;
                m_ptr   = (m_owner + 1) % W;
                m_owner = -1;
            end
        end
    endtask

    initial begin
        tv[0]  = '{3'b001, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0};
        tv[1]  = '{3'b001, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 0, 0};
        tv[2]  = '{3'b001, 3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 0, 0};
        tv[3]  = '{3'b011, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 1};
        tv[4]  = '{3'b011, 3'b001, 3'b001, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1, 1};
        tv[5]  = '{3'b111, 3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1, 1};
        tv[6]  = '{3'b001, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 2};
        tv[7]  = '{3'b000, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 0, 2};
        tv[8]  = '{3'b111, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 0, 2};
        tv[9]  = '{3'b111, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 2};
        tv[10] = '{3'b111, 3'b000, 3'b000, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1, 2};
        order = '{0, 1, 2, 0};

        // reset state
        do_reset();
        check("rst grant", int'(grant_o), 0);
        check("rst sel", int'(sel_o), 0);
        check("rst busy", int'(busy_o), 0);
        check("rst abort", int'(abort_o), 0);
        check("rst frames", int'(frames_o), 0);

        // cycle-by-cycle vector table
        for (int i = 0; i < 11; i++) begin
            drive(tv[i].req, tv[i].valid, tv[i].last, tv[i].ready);
            check($sformatf("vec%0d grant", i), int'(grant_o), int'(tv[i].grant));
            check($sformatf("vec%0d busy", i), int'(busy_o), int'(tv[i].busy));
            check($sformatf("vec%0d abort", i), int'(abort_o), int'(tv[i].abort));
            check($sformatf("vec%0d xfer", i), int'(xfer_o), int'(tv[i].xfer));
            check($sformatf("vec%0d frames", i), int'(frames_o), tv[i].frames);
            if (tv[i].busy) check($sformatf("vec%0d sel", i), int'(sel_o), tv[i].sel);
            tick();
        end

        // round robin over three requesters, 4-beat frames
        do_reset();
        for (int f = 0; f < 4; f++) begin
            idle = 0;
            drive(3'b111, 3'b000, 3'b000, 1'b1);
            while (grant_o == 3'b000 && idle < 6) begin
                idle++;
                tick();
            end
            check($sformatf("rr grant f%0d", f), int'(grant_o), 1 << order[f]);
            check($sformatf("rr gap f%0d", f), idle, 1);
            for (int b = 0; b < 4; b++) begin
                drive(3'b111, 3'b111, (b == 3) ? (3'b001 << order[f]) : 3'b000, 1'b1);
                tick();
            end
        end
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        check("rr frames", int'(frames_o), 4);

        // late request from port 2 while port 1 owns the output
        do_reset();
        drive(3'b010, 3'b000, 3'b000, 1'b1);
        tick();
        check("hold grant p1", int'(grant_o), 3'b010);
        for (int b = 0; b < 4; b++) begin
            drive((b == 0) ? 3'b010 : 3'b110, 3'b110, (b == 3) ? 3'b010 : 3'b100, 1'b1);
            check($sformatf("hold b%0d grant", b), int'(grant_o), 3'b010);
            tick();
        end
        drive(3'b100, 3'b000, 3'b000, 1'b1);
        check("hold gap grant", int'(grant_o), 0);
        tick();
        check("hold p2 grant", int'(grant_o), 3'b100);

        // watchdog at 8 beats without last
        do_reset();
        drive(3'b011, 3'b000, 3'b000, 1'b1);
        tick();
        for (int b = 0; b < 8; b++) begin
            drive(3'b011, 3'b001, 3'b000, 1'b1);
            check($sformatf("wd b%0d abort", b), int'(abort_o), 0);
            check($sformatf("wd b%0d grant", b), int'(grant_o), 3'b001);
            tick();
        end
        check("wd abort", int'(abort_o), 1);
        check("wd grant", int'(grant_o), 0);
        check("wd frames", int'(frames_o), 0);
        pulses = int'(abort_o);
        n = 0;
        drive(3'b011, 3'b000, 3'b000, 1'b1);
        while (grant_o == 3'b000 && n < 6) begin
            tick();
            n++;
            pulses += int'(abort_o);
        end
        check("wd pulses", pulses, 1);
        check("wd next grant", int'(grant_o), 3'b010);

        // ready toggling across a 6-beat frame
        do_reset();
        drive(3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        sent = 0; xfers = 0; aborts = 0; n = 0;
        while (sent < 6 && n < 20) begin
            rd = (n % 2 == 0);
            drive(3'b001, 3'b001, (sent == 5) ? 3'b001 : 3'b000, rd);
            check($sformatf("tog c%0d xfer", n), int'(xfer_o), int'(rd));
            xfers  += int'(xfer_o);
            aborts += int'(abort_o);
            if (rd) sent++;
            n++;
            tick();
        end
        aborts += int'(abort_o);
        check("tog xfers", xfers, 6);
        check("tog aborts", aborts, 0);
        check("tog frames", int'(frames_o), 1);
        check("tog grant", int'(grant_o), 0);

        // asynchronous reset mid-frame
        do_reset();
        drive(3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        drive(3'b001, 3'b001, 3'b000, 1'b1);
        tick();
        #3 rst_i = 1'b1;
        #1;
        check("async grant", int'(grant_o), 0);
        check("async busy", int'(busy_o), 0);
        check("async abort", int'(abort_o), 0);
        tick();
        check("async abort held", int'(abort_o), 0);
        rst_i = 1'b0;
        drive(3'b100, 3'b000, 3'b000, 1'b1);
        check("async idle", int'(grant_o), 0);
        tick();
        check("async p2 grant", int'(grant_o), 3'b100);
        check("async p2 sel", int'(sel_o), 2);

        // request dropped at beat 3
        do_reset();
        drive(3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        drive(3'b001, 3'b001, 3'b000, 1'b1);
        tick();
        drive(3'b001, 3'b001, 3'b000, 1'b1);
        tick();
        drive(3'b000, 3'b001, 3'b000, 1'b1);
        check("drop xfer", int'(xfer_o), 1);
        tick();
        check("drop abort", int'(abort_o), 1);
        check("drop grant", int'(grant_o), 0);
        pulses = int'(abort_o);
        for (int c = 0; c < 3; c++) begin
            drive(3'b000, 3'b000, 3'b000, 1'b1);
            tick();
            pulses += int'(abort_o);
        end
        check("drop pulses", pulses, 1);
        check("drop idle busy", int'(busy_o), 0);
        check("drop frames", int'(frames_o), 0);

        // last on the watchdog beat completes normally
        do_reset();
        drive(3'b001, 3'b000, 3'b000, 1'b1);
        tick();
        for (int b = 0; b < 8; b++) begin
            drive(3'b001, 3'b001, (b == 7) ? 3'b001 : 3'b000, 1'b1);
            tick();
        end
        check("lastwd frames", int'(frames_o), 1);
        check("lastwd abort", int'(abort_o), 0);
        check("lastwd grant", int'(grant_o), 0);
        drive(3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        check("lastwd abort2", int'(abort_o), 0);

        // randomized traffic against the reference model
        do_reset();
        m_owner = -1; m_ptr = 0; m_beats = 0; m_sel = 0; m_abort = 0; m_frames = 0;
        r_req = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            r_req   = r_req ^ (3'($urandom) & 3'($urandom) & 3'($urandom) & 3'($urandom));
            r_valid = 3'($urandom) | 3'($urandom);
            r_last  = 3'($urandom) & 3'($urandom) & 3'($urandom);
            r_rdy   = ($urandom_range(0, 3) != 0);
            drive(r_req, r_valid, r_last, r_rdy);
            model_eval();
            check($sformatf("rnd c%0d grant", c), int'(grant_o), e_grant);
            check($sformatf("rnd c%0d busy", c), int'(busy_o), e_busy);
            check($sformatf("rnd c%0d abort", c), int'(abort_o), e_abort);
            check($sformatf("rnd c%0d xfer", c), int'(xfer_o), e_xfer);
            check($sformatf("rnd c%0d frames", c), int'(frames_o), m_frames);
            if (e_busy == 1) check($sformatf("rnd c%0d sel", c), int'(sel_o), m_sel);
            model_next();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
